// File: rtl/p2s_frame_tx.sv
// Ping-pong framed serializer: fills one WORDS-deep buffer from the daisy chain
// while the other one shifts out MSB first on s_data, framed by data_valid.
module p2s_frame_tx #(
    parameter int BITS_ADC = 12,
    parameter int WORDS    = 32,
    parameter int GAP_CYC  = 4
) (
    input  logic                clk_50M,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                in_valid,
    input  logic [BITS_ADC-1:0] in_data,
    input  logic                clr_overflow,
    output logic                s_data,
    output logic                data_valid,
    output logic                busy,
    output logic                overflow
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int BW = (BITS_ADC > 1) ? $clog2(BITS_ADC) : 1;
    localparam int GW = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);
    localparam logic [BW-1:0] BIT_TOP  = BW'(BITS_ADC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC >= 2) ? GAP_CYC - 2 : 0);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    logic [BITS_ADC-1:0] mem [2][WORDS];
    logic [1:0]          full, full_nxt, full_q;
    logic                fill_ptr, tx_ptr;
    logic [IW-1:0]       idx, wr_idx;
    logic                wr_en, wr_last, drop;

    state_t              state, state_nxt;
    logic [BW-1:0]       bitcnt, bit_nxt;
    logic [IW-1:0]       wordcnt, word_nxt;
    logic [GW-1:0]       gapcnt, gap_nxt;
    logic                load, adv, release_buf, sd_nxt, dv_nxt;

    // ---------------- fill side ----------------
    assign wr_idx  = frame_start ? '0 : idx;
    assign drop    = in_valid && full[fill_ptr];
    assign wr_en   = in_valid && !full[fill_ptr];
    assign wr_last = wr_en && (wr_idx == IDX_LAST);

    always_ff @(posedge clk_50M) begin
        if (wr_en)
            mem[fill_ptr][wr_idx] <= in_data;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            fill_ptr <= 1'b0;
        end else if (wr_last) begin
            idx      <= '0;
            fill_ptr <= ~fill_ptr;
        end else if (wr_en) begin
            idx      <= wr_idx + IW'(1);
        end else if (frame_start) begin
            idx      <= '0;
        end
    end

    // Set and release never target the same buffer: set needs it empty, release needs it full.
    always_comb begin
        full_nxt = full;
        if (release_buf) full_nxt[tx_ptr]   = 1'b0;
        if (wr_last)     full_nxt[fill_ptr] = 1'b1;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            full     <= '0;
            full_q   <= '0;
            overflow <= 1'b0;
        end else begin
            full     <= full_nxt;
            full_q   <= full;
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

    // ---------------- shift side ----------------
    // FSM looks at the delayed full flag, so the first bit appears two edges after the last write.
    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        adv         = 1'b0;
        release_buf = 1'b0;
        unique case (state)
            IDLE: if (full_q[tx_ptr]) begin
                state_nxt = SHIFT;
                load      = 1'b1;
            end
            SHIFT: if (bitcnt == '0 && wordcnt == IDX_LAST) begin
                release_buf = 1'b1;
                // the IDLE cycle supplies one low cycle, GAP the remaining GAP_CYC-1
                state_nxt   = (GAP_CYC > 1) ? GAP : IDLE;
            end else begin
                adv = 1'b1;
            end
            GAP: if (gapcnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bit_nxt  = bitcnt;
        word_nxt = wordcnt;
        if (load) begin
            bit_nxt  = BIT_TOP;
            word_nxt = '0;
        end else if (adv) begin
            if (bitcnt == '0) begin
                bit_nxt  = BIT_TOP;
                word_nxt = wordcnt + IW'(1);
            end else begin
                bit_nxt  = bitcnt - BW'(1);
            end
        end else if (release_buf) begin
            bit_nxt  = '0;
            word_nxt = '0;
        end
        dv_nxt  = load || adv;
        sd_nxt  = dv_nxt ? mem[tx_ptr][word_nxt][bit_nxt] : 1'b0;
        gap_nxt = (state == GAP && state_nxt == GAP) ? gapcnt + GW'(1) : '0;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bitcnt     <= '0;
            wordcnt    <= '0;
            gapcnt     <= '0;
            tx_ptr     <= 1'b0;
            s_data     <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            bitcnt     <= bit_nxt;
            wordcnt    <= word_nxt;
            gapcnt     <= gap_nxt;
            s_data     <= sd_nxt;
            data_valid <= dv_nxt;
            if (release_buf) tx_ptr <= ~tx_ptr;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_p2s_frame_tx.sv
// Bench for p2s_frame_tx: a frame-level model (word queues, drop rule, latency/gap
// arithmetic) checked against a serial monitor that rebuilds frames from s_data.
module tb_p2s_frame_tx;
    localparam int BITS = 12;
    localparam int WORDS = 32;
    localparam int GAP = 4;
    localparam int FB = BITS * WORDS;
    typedef logic [FB-1:0] frame_t;

    logic            clk_50M = 1'b0;
    logic            rst_n = 1'b0;
    logic            frame_start = 1'b0;
    logic            in_valid = 1'b0;
    logic [BITS-1:0] in_data = '0;
    logic            clr_overflow = 1'b0;
    logic            s_data, data_valid, busy, overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    p2s_frame_tx #(.BITS_ADC(BITS), .WORDS(WORDS), .GAP_CYC(GAP)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .frame_start(frame_start),
        .in_valid(in_valid), .in_data(in_data), .clr_overflow(clr_overflow),
        .s_data(s_data), .data_valid(data_valid), .busy(busy), .overflow(overflow)
    );

    always #10 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    // serial monitor: rebuild frames, note rise/fall cycles and in-frame toggles
    frame_t rx_frames[$];
    int     rise_q[$], fall_q[$], tog_q[$];
    frame_t rx_bits = '0;
    int     nbits = 0, tog = 0, rise_tmp = 0, bad_frames = 0, idle_glitch = 0;
    logic   prev_sd = 1'b0;

    always @(negedge clk_50M) begin
        if (rst_n && data_valid === 1'b1) begin
            if (nbits < FB) rx_bits[FB-1-nbits] <= s_data;
            nbits   <= nbits + 1;
            prev_sd <= s_data;
            if (nbits == 0) begin
                rise_tmp <= cyc;
                tog      <= 0;
            end else if (s_data !== prev_sd) begin
                tog <= tog + 1;
            end
        end else begin
            if (rst_n && s_data !== 1'b0) idle_glitch <= idle_glitch + 1;
            if (rst_n && nbits == FB) begin
                rx_frames.push_back(rx_bits);
                rise_q.push_back(rise_tmp);
                fall_q.push_back(cyc);
                tog_q.push_back(tog);
            end else if (nbits != 0) begin
                bad_frames <= bad_frames + 1;
            end
            nbits <= 0;
        end
    end

    // reference model state
    frame_t model_frames[$];
    int     n_last_q[$];
    frame_t cur_v = '0;
    int     cur_n = 0;
    logic   ov_m = 1'b0;
    int     checked = 0;

    function automatic logic [BITS-1:0] word_of(input frame_t f, input int k);
        return f[FB-1-BITS*k -: BITS];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one word; a word is dropped when two finished frames are still untransmitted.
    task automatic wr(input logic [BITS-1:0] d, input logic fs, input logic clr);
        @(negedge clk_50M); #1;
        chk("overflow", {31'd0, overflow}, {31'd0, ov_m});
        in_valid = 1'b1; in_data = d; frame_start = fs; clr_overflow = clr;
        if (fs) cur_n = 0;
        if (model_frames.size() - rx_frames.size() >= 2) begin
            ov_m = 1'b1;
        end else begin
            cur_v[FB-1-BITS*cur_n -: BITS] = d;
            cur_n++;
            if (cur_n == WORDS) begin
                model_frames.push_back(cur_v);
                n_last_q.push_back(cyc + 1);
                cur_n = 0;
            end
            if (clr) ov_m = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_50M); #1;
            in_valid = 1'b0; frame_start = 1'b0; clr_overflow = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 5000; t++) begin
            if (rx_frames.size() >= model_frames.size() && !busy && !data_valid) break;
            @(negedge clk_50M);
        end
        chk({tag, " frame count"}, rx_frames.size(), model_frames.size());
    endtask

    // contents, and rise = max(last write + 2, previous fall + GAP)
    task automatic check_new_frames(input string tag);
        for (int i = checked; i < model_frames.size() && i < rx_frames.size(); i++) begin
            int mism = 0;
            int exp_rise = n_last_q[i] + 2;
            for (int k = 0; k < WORDS; k++)
                if (word_of(rx_frames[i], k) !== word_of(model_frames[i], k)) mism++;
            chk({tag, " word mismatches"}, mism, 0);
            if (i > 0 && fall_q[i-1] + GAP > exp_rise) exp_rise = fall_q[i-1] + GAP;
            chk({tag, " rise cycle"}, rise_q[i], exp_rise);
        end
        checked = model_frames.size();
    endtask

    initial begin
        // reset state
        idle(3);
        chk("reset s_data", {31'd0, s_data}, 0);
        chk("reset data_valid", {31'd0, data_valid}, 0);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset overflow", {31'd0, overflow}, 0);
        @(negedge clk_50M); #1; rst_n = 1'b1;
        idle(2);

        // T2 single frame, k*0x081
        for (int k = 0; k < WORDS; k++) wr(BITS'(k * 12'h081), 1'b0, 1'b0);
        idle(1);
        drain("T2");
        check_new_frames("T2");
        if (rx_frames.size() > 0) begin
            chk("T2 blk0_ch3", word_of(rx_frames[0], 0), 12'h000);
            chk("T2 blk7_ch0", word_of(rx_frames[0], WORDS-1), 12'hF9F);
        end

        // T6 constant patterns back to back
        for (int k = 0; k < WORDS; k++) wr(12'hFFF, 1'b0, 1'b0);
        for (int k = 0; k < WORDS; k++) wr(12'h000, 1'b0, 1'b0);
        idle(1);
        drain("T6");
        for (int i = checked; i < rx_frames.size(); i++) chk("T6 toggles", tog_q[i], 0);
        check_new_frames("T6");
        if (rx_frames.size() >= 3) chk("T6 gap", rise_q[2] - fall_q[1], GAP);

        // T5 frame_start restart with simultaneous word
        for (int k = 0; k < 10; k++) wr(BITS'($urandom), 1'b0, 1'b0);
        wr(12'hABC, 1'b1, 1'b0);
        for (int k = 1; k < WORDS; k++) wr(BITS'($urandom), 1'b0, 1'b0);
        idle(1);
        drain("T5");
        check_new_frames("T5");
        if (rx_frames.size() > 0) chk("T5 word0", word_of(rx_frames[rx_frames.size()-1], 0), 12'hABC);

        // T3 slow fill, one word per 16 clocks
        for (int k = 0; k < 2 * WORDS; k++) begin
            wr(BITS'($urandom), 1'b0, 1'b0);
            idle(15);
        end
        drain("T3");
        check_new_frames("T3");
        chk("T3 overflow", {31'd0, overflow}, 0);

        // T4 full-rate burst of 96, clr_overflow together with a dropped word
        for (int k = 0; k < 3 * WORDS; k++) wr(BITS'($urandom), 1'b0, (k == 80));
        idle(1);
        chk("T4 overflow sticky", {31'd0, overflow}, 1);
        drain("T4");
        check_new_frames("T4");
        @(negedge clk_50M); #1; clr_overflow = 1'b1; ov_m = 1'b0;
        idle(1);
        chk("T4 overflow cleared", {31'd0, overflow}, 0);

        // T1 reset during SHIFT, then a clean frame
        for (int k = 0; k < WORDS; k++) wr(BITS'($urandom), 1'b0, 1'b0);
        idle(1);
        for (int t = 0; t < 100 && !data_valid; t++) @(negedge clk_50M);
        chk("T1 shifting", {31'd0, data_valid}, 1);
        idle(50);
        rst_n = 1'b0;
        #1;
        chk("T1 s_data", {31'd0, s_data}, 0);
        chk("T1 data_valid", {31'd0, data_valid}, 0);
        chk("T1 busy", {31'd0, busy}, 0);
        chk("T1 overflow", {31'd0, overflow}, 0);
        while (model_frames.size() > rx_frames.size()) begin
            void'(model_frames.pop_back());
            void'(n_last_q.pop_back());
        end
        checked = model_frames.size();
        cur_n = 0; ov_m = 1'b0;
        idle(5);
        rst_n = 1'b1;
        idle(2);
        for (int k = 0; k < WORDS; k++) wr(BITS'($urandom), 1'b0, 1'b0);
        idle(1);
        drain("T1");
        check_new_frames("T1");
        chk("aborted frames", bad_frames, 1);
        chk("s_data low outside frames", idle_glitch, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
